// File: rtl/mioc_asic.sv
// mioc_asic - memory and I/O controller for the ADAM computer board.
//
// Decodes Z80 buffered bus cycles against a 4-bit memory-map register and
// drives the ROM/region chip selects. It runs the DRAM RAS/MUX/CAS
// sequencer and multiplexes the DRAM address MSB (RA7). During refresh,
// RA7 carries an extra refresh address bit. It also stretches the system
// and AdamNET resets and turns 6801 DMA requests into Z80 bus requests.
//
// Ports
//   B_PHI                      Z80 clock; all registers update on its rising edge
//   PBRST_N, N_CVRST           computer-mode / game-mode reset requests (either one resets)
//   BA15,BA14,BA13,BA7,BA6     buffered address bits
//   BD3..BD0                   buffered data, low nibble (memory-map writes)
//   N_BWR,BRD_N,BMREQ_N,IORQ_N,BM1_N,BRFSH_N   Z80 buffered strobes, active low
//   WAIT_N,BUSAK_N,DMA_N,OS3_N wait, bus ack, 6801 DMA request, 6801 status
//   RA7                        DRAM address MSB
//   RAS_N,CAS1_N,CAS2_N,MUX    DRAM strobes (CAS1 internal 64K, CAS2 expansion 64K)
//                              and row/column select
//   BOOTROMCS_N,AUXROMCS_N,AUXDECODE1_N,EN245_N   region selects, active low
//   RST_N,CPRST_N,NETRST_N     stretched reset outputs, active low
//   BUSRQ_N,ADDRBUFEN_N        Z80 bus request, Z80 address buffer enable
//   SPINDIS_N,IS3_N            spinner interrupt disable, 6801 I/O strobe

module mioc_asic (
    input  logic B_PHI,
    input  logic PBRST_N,
    input  logic N_CVRST,
    input  logic BA15,
    input  logic BA14,
    input  logic BA13,
    input  logic BA7,
    input  logic BA6,
    input  logic BD3,
    input  logic BD2,
    input  logic BD1,
    input  logic BD0,
    input  logic N_BWR,
    input  logic BRD_N,
    input  logic BMREQ_N,
    input  logic IORQ_N,
    input  logic BM1_N,
    input  logic BRFSH_N,
    input  logic WAIT_N,
    input  logic BUSAK_N,
    input  logic DMA_N,
    input  logic OS3_N,
    output logic RA7,
    output logic RAS_N,
    output logic CAS1_N,
    output logic CAS2_N,
    output logic MUX,
    output logic BOOTROMCS_N,
    output logic AUXROMCS_N,
    output logic AUXDECODE1_N,
    output logic EN245_N,
    output logic RST_N,
    output logic CPRST_N,
    output logic NETRST_N,
    output logic BUSRQ_N,
    output logic ADDRBUFEN_N,
    output logic SPINDIS_N,
    output logic IS3_N
);

    typedef enum logic [1:0] {ST_IDLE, ST_ROW, ST_COL} dram_st_e;
    typedef enum logic [1:0] {TGT_NONE, TGT_INT, TGT_EXP} ram_tgt_e;

    logic       sys_rst;
    logic       io_acc;
    logic       map_wr;
    logic       mem_vld;
    logic       ram_hit;
    logic       dec_boot, dec_aux1, dec_auxrom, dec_en245, dec_int, dec_exp;
    logic       rfsh_msb_d;
    // Wait states only stretch BMREQ_N, which the sequencer already follows.
    logic       unused_wait;

    logic [3:0] map_q;
    dram_st_e   st_q;
    ram_tgt_e   tgt_q;
    logic       rfsh_q;
    logic       ras_n_q, mux_q, cas1_n_q, cas2_n_q, ra7_q;
    logic       rfsh_msb_q, rfsh_ba6_q;
    logic       spindis_n_q, busrq_n_q, addrbufen_n_q;
    logic [2:0] rcnt_q;
    logic       rst_n_q;

    assign unused_wait = WAIT_N;

    assign sys_rst = !PBRST_N || !N_CVRST;
    // BM1_N low with IORQ_N low is an interrupt acknowledge, not an I/O access.
    assign io_acc  = !IORQ_N && BM1_N;
    assign map_wr  = io_acc && !N_BWR && !BA7 && BA6;
    assign mem_vld = !BMREQ_N && BRFSH_N && (!BRD_N || !N_BWR);

    // Region decode from the memory map; a 6801 DMA cycle always hits internal RAM.
    always_comb begin
        dec_boot   = 1'b0;
        dec_aux1   = 1'b0;
        dec_auxrom = 1'b0;
        dec_en245  = 1'b0;
        dec_int    = 1'b0;
        dec_exp    = 1'b0;
        if (!DMA_N) begin
            dec_int = 1'b1;
        end else if (!BA15) begin
            case (map_q[1:0])
                2'b00:   dec_boot = 1'b1;
                2'b01:   dec_int  = 1'b1;
                2'b10:   dec_exp  = 1'b1;
                default: begin
                    if (!BA14 && !BA13) dec_aux1 = 1'b1;
                    else                dec_int  = 1'b1;
                end
            endcase
        end else begin
            case (map_q[3:2])
                2'b00:   dec_int    = 1'b1;
                2'b01:   dec_exp    = 1'b1;
                2'b10:   dec_auxrom = 1'b1;
                default: dec_en245  = 1'b1;
            endcase
        end
    end

    assign ram_hit = mem_vld && (dec_int || dec_exp);

    assign BOOTROMCS_N  = !(mem_vld && dec_boot);
    assign AUXDECODE1_N = !(mem_vld && dec_aux1);
    assign AUXROMCS_N   = !(mem_vld && dec_auxrom);
    assign EN245_N      = !(mem_vld && dec_en245);

    // OS3_N low means the 6801 owns the strobe, so it is held inactive.
    assign IS3_N = !(io_acc && !BA7 && !BA6 && OS3_N && !sys_rst);

    // The 8th refresh bit flips when the refresh address wraps from the
    // top of a 7-bit page (BA6 high) back to its bottom (BA7:BA6 = 00).
    assign rfsh_msb_d = rfsh_msb_q ^ (rfsh_ba6_q && !BA7 && !BA6);

    always_ff @(posedge B_PHI) begin
        if (!PBRST_N)        map_q <= 4'b0000;
        else if (!N_CVRST)   map_q <= 4'b1111;
        else if (map_wr)     map_q <= {BD3, BD2, BD1, BD0};
    end

    // DRAM sequencer; strobes are registered together with the state so they
    // change on the same edge as the state they belong to.
    always_ff @(posedge B_PHI) begin
        if (sys_rst) begin
            st_q       <= ST_IDLE;
            tgt_q      <= TGT_NONE;
            rfsh_q     <= 1'b0;
            ras_n_q    <= 1'b1;
            mux_q      <= 1'b0;
            cas1_n_q   <= 1'b1;
            cas2_n_q   <= 1'b1;
            ra7_q      <= 1'b0;
            rfsh_msb_q <= 1'b0;
            rfsh_ba6_q <= 1'b0;
        end else if (BMREQ_N) begin
            // End of cycle or abort: release everything from any state.
            st_q     <= ST_IDLE;
            tgt_q    <= TGT_NONE;
            rfsh_q   <= 1'b0;
            ras_n_q  <= 1'b1;
            mux_q    <= 1'b0;
            cas1_n_q <= 1'b1;
            cas2_n_q <= 1'b1;
            ra7_q    <= BA7;
        end else begin
            case (st_q)
                ST_IDLE: begin
                    if (ram_hit || !BRFSH_N) begin
                        st_q    <= ST_ROW;
                        ras_n_q <= 1'b0;
                        mux_q   <= 1'b0;
                        rfsh_q  <= !BRFSH_N;
                        // Target is latched so a map write mid-cycle cannot retarget CAS.
                        if (mem_vld && dec_exp)      tgt_q <= TGT_EXP;
                        else if (mem_vld && dec_int) tgt_q <= TGT_INT;
                        else                         tgt_q <= TGT_NONE;
                        if (!BRFSH_N) begin
                            rfsh_msb_q <= rfsh_msb_d;
                            rfsh_ba6_q <= BA6;
                            ra7_q      <= rfsh_msb_d;
                        end else begin
                            ra7_q <= BA7;
                        end
                    end else begin
                        ra7_q <= BA7;
                    end
                end
                ST_ROW: begin
                    if (rfsh_q) begin
                        ra7_q <= rfsh_msb_q;
                    end else begin
                        st_q     <= ST_COL;
                        mux_q    <= 1'b1;
                        cas1_n_q <= (tgt_q != TGT_INT);
                        cas2_n_q <= (tgt_q != TGT_EXP);
                        ra7_q    <= BA15;
                    end
                end
                ST_COL: begin
                    ra7_q <= BA15;
                end
                default: begin
                    st_q     <= ST_IDLE;
                    ras_n_q  <= 1'b1;
                    mux_q    <= 1'b0;
                    cas1_n_q <= 1'b1;
                    cas2_n_q <= 1'b1;
                    ra7_q    <= BA7;
                end
            endcase
        end
    end

    always_ff @(posedge B_PHI) begin
        if (sys_rst) begin
            spindis_n_q   <= 1'b1;
            busrq_n_q     <= 1'b1;
            addrbufen_n_q <= 1'b0;
        end else begin
            if (io_acc && BA7) spindis_n_q <= BA6;
            busrq_n_q     <= DMA_N;
            addrbufen_n_q <= !DMA_N && !BUSAK_N;
        end
    end

    // Reset stretcher: outputs rise on the 4th edge after sys_rst releases.
    always_ff @(posedge B_PHI) begin
        if (sys_rst) begin
            rcnt_q  <= 3'd0;
            rst_n_q <= 1'b0;
        end else if (rcnt_q != 3'd4) begin
            rcnt_q  <= rcnt_q + 3'd1;
            rst_n_q <= (rcnt_q == 3'd3);
        end
    end

    assign RA7         = ra7_q;
    assign RAS_N       = ras_n_q;
    assign MUX         = mux_q;
    assign CAS1_N      = cas1_n_q;
    assign CAS2_N      = cas2_n_q;
    assign RST_N       = rst_n_q;
    assign CPRST_N     = rst_n_q;
    assign NETRST_N    = rst_n_q;
    assign BUSRQ_N     = busrq_n_q;
    assign ADDRBUFEN_N = addrbufen_n_q;
    assign SPINDIS_N   = spindis_n_q;

endmodule

// File: tb/tb_mioc_asic.sv
// Testbench for mioc_asic: directed bring-up sequences followed by random
// bus activity, every clock compared against a cycle-count reference model.

module tb_mioc_asic;

    localparam int R_NONE = 0, R_INT = 1, R_EXP = 2, R_BOOT = 3,
                   R_AUX1 = 4, R_AUXROM = 5, R_EN245 = 6;

    logic B_PHI = 1'b0;
    logic PBRST_N, N_CVRST, BA15, BA14, BA13, BA7, BA6, BD3, BD2, BD1, BD0;
    logic N_BWR, BRD_N, BMREQ_N, IORQ_N, BM1_N, BRFSH_N, WAIT_N, BUSAK_N, DMA_N, OS3_N;
    wire  RA7, RAS_N, CAS1_N, CAS2_N, MUX, BOOTROMCS_N, AUXROMCS_N, AUXDECODE1_N, EN245_N;
    wire  RST_N, CPRST_N, NETRST_N, BUSRQ_N, ADDRBUFEN_N, SPINDIS_N, IS3_N;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int m_map, m_cnt, m_tgt, m_rcnt;
    bit m_rf, m_msb, m_prev6, m_spin, m_busrq, m_abuf;

    always #10 B_PHI = ~B_PHI;

    mioc_asic dut (
        .B_PHI(B_PHI), .PBRST_N(PBRST_N), .N_CVRST(N_CVRST),
        .BA15(BA15), .BA14(BA14), .BA13(BA13), .BA7(BA7), .BA6(BA6),
        .BD3(BD3), .BD2(BD2), .BD1(BD1), .BD0(BD0),
        .N_BWR(N_BWR), .BRD_N(BRD_N), .BMREQ_N(BMREQ_N), .IORQ_N(IORQ_N),
        .BM1_N(BM1_N), .BRFSH_N(BRFSH_N), .WAIT_N(WAIT_N), .BUSAK_N(BUSAK_N),
        .DMA_N(DMA_N), .OS3_N(OS3_N),
        .RA7(RA7), .RAS_N(RAS_N), .CAS1_N(CAS1_N), .CAS2_N(CAS2_N), .MUX(MUX),
        .BOOTROMCS_N(BOOTROMCS_N), .AUXROMCS_N(AUXROMCS_N),
        .AUXDECODE1_N(AUXDECODE1_N), .EN245_N(EN245_N),
        .RST_N(RST_N), .CPRST_N(CPRST_N), .NETRST_N(NETRST_N),
        .BUSRQ_N(BUSRQ_N), .ADDRBUFEN_N(ADDRBUFEN_N),
        .SPINDIS_N(SPINDIS_N), .IS3_N(IS3_N)
    );

    task automatic check_eq(input string tag, input logic got, input logic exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%b expected=%b at %0t", tag, got, exp, $time);
        end
    endtask

    // Memory map table: which region an access at this address goes to.
    function automatic int region_of(int map, logic a15, logic a14, logic a13, logic dma_n);
        int lo, hi;
        lo = map % 4;
        hi = map / 4;
        if (!dma_n) return R_INT;
        if (!a15) begin
            if (lo == 0) return R_BOOT;
            if (lo == 1) return R_INT;
            if (lo == 2) return R_EXP;
            return (!a14 && !a13) ? R_AUX1 : R_INT;
        end
        if (hi == 0) return R_INT;
        if (hi == 1) return R_EXP;
        if (hi == 2) return R_AUXROM;
        return R_EN245;
    endfunction

    // One clock: advance the model with the inputs seen at the edge, then compare.
    task automatic tick();
        bit rst, vld, io, mux_e;
        int rg;
        @(posedge B_PHI);
        rst = !PBRST_N || !N_CVRST;
        vld = !BMREQ_N && BRFSH_N && (!BRD_N || !N_BWR);
        io  = !IORQ_N && BM1_N;
        rg  = region_of(m_map, BA15, BA14, BA13, DMA_N);

        // m_cnt = number of edges the current DRAM cycle has been running
        if (rst || BMREQ_N) begin
            m_cnt = 0;
            m_rf  = 1'b0;
        end else if (m_cnt == 0) begin
            if (!BRFSH_N || (vld && (rg == R_INT || rg == R_EXP))) begin
                m_cnt = 1;
                m_rf  = !BRFSH_N;
                m_tgt = (vld && (rg == R_INT || rg == R_EXP)) ? rg : R_NONE;
                if (m_rf) begin
                    if (!BA7 && !BA6 && m_prev6) m_msb = !m_msb;
                    m_prev6 = BA6;
                end
            end
        end else if (m_cnt < 1000) begin
            m_cnt++;
        end
        if (rst) begin
            m_msb   = 1'b0;
            m_prev6 = 1'b0;
        end

        if (!PBRST_N)                          m_map = 0;
        else if (!N_CVRST)                     m_map = 15;
        else if (io && !N_BWR && !BA7 && BA6)  m_map = {BD3, BD2, BD1, BD0};

        if (rst)              m_spin = 1'b1;
        else if (io && BA7)   m_spin = BA6;
        m_busrq = rst ? 1'b1 : DMA_N;
        m_abuf  = rst ? 1'b0 : (!DMA_N && !BUSAK_N);
        m_rcnt  = rst ? 0 : ((m_rcnt < 4) ? m_rcnt + 1 : 4);

        #1;
        mux_e = (m_cnt >= 2) && !m_rf;
        check_eq("RAS_N", RAS_N, !(m_cnt >= 1));
        check_eq("MUX", MUX, mux_e);
        check_eq("CAS1_N", CAS1_N, !(mux_e && m_tgt == R_INT));
        check_eq("CAS2_N", CAS2_N, !(mux_e && m_tgt == R_EXP));
        if (rst)                     check_eq("RA7", RA7, 1'b0);
        else if (m_cnt >= 1 && m_rf) check_eq("RA7", RA7, m_msb);
        else                         check_eq("RA7", RA7, mux_e ? BA15 : BA7);
        check_eq("RST_N", RST_N, m_rcnt >= 4);
        check_eq("CPRST_N", CPRST_N, m_rcnt >= 4);
        check_eq("NETRST_N", NETRST_N, m_rcnt >= 4);
        check_eq("BUSRQ_N", BUSRQ_N, m_busrq);
        check_eq("ADDRBUFEN_N", ADDRBUFEN_N, m_abuf);
        check_eq("SPINDIS_N", SPINDIS_N, m_spin);

        rg = region_of(m_map, BA15, BA14, BA13, DMA_N);
        check_eq("BOOTROMCS_N", BOOTROMCS_N, !(vld && rg == R_BOOT));
        check_eq("AUXDECODE1_N", AUXDECODE1_N, !(vld && rg == R_AUX1));
        check_eq("AUXROMCS_N", AUXROMCS_N, !(vld && rg == R_AUXROM));
        check_eq("EN245_N", EN245_N, !(vld && rg == R_EN245));
        check_eq("IS3_N", IS3_N, !(io && !BA7 && !BA6 && OS3_N && !rst));
    endtask

    task automatic bus_idle();
        PBRST_N = 1'b1; N_CVRST = 1'b1;
        N_BWR = 1'b1; BRD_N = 1'b1; BMREQ_N = 1'b1; IORQ_N = 1'b1;
        BM1_N = 1'b1; BRFSH_N = 1'b1; WAIT_N = 1'b1; BUSAK_N = 1'b1;
        DMA_N = 1'b1; OS3_N = 1'b1;
    endtask

    task automatic set_addr(input logic a15, input logic a14, input logic a13,
                            input logic a7, input logic a6);
        BA15 = a15; BA14 = a14; BA13 = a13; BA7 = a7; BA6 = a6;
    endtask

    task automatic set_data(input logic [3:0] d);
        {BD3, BD2, BD1, BD0} = d;
    endtask

    initial begin
        logic [1:0] rf_pat [4];
        logic       rf_ra7 [4];
        m_map = 0; m_cnt = 0; m_tgt = R_NONE; m_rcnt = 0;
        m_rf = 0; m_msb = 0; m_prev6 = 0; m_spin = 1; m_busrq = 1; m_abuf = 0;
        bus_idle();
        set_addr(0, 0, 0, 0, 0);
        set_data(4'h0);

        // Power-on reset pulse of 1000 ns, then the 4-clock stretch
        PBRST_N = 1'b0;
        repeat (50) tick();
        check_eq("reset_RST_N_low", RST_N, 1'b0);
        check_eq("reset_RAS_N", RAS_N, 1'b1);
        check_eq("reset_RA7", RA7, 1'b0);
        PBRST_N = 1'b1;
        repeat (3) tick();
        check_eq("stretch_RST_N_3clk", RST_N, 1'b0);
        tick();
        check_eq("stretch_RST_N_4clk", RST_N, 1'b1);
        check_eq("stretch_NETRST_N_4clk", NETRST_N, 1'b1);

        // Refresh cycles with BA7:BA6 = 01, 10, 11, 00
        rf_pat[0] = 2'b01; rf_pat[1] = 2'b10; rf_pat[2] = 2'b11; rf_pat[3] = 2'b00;
        rf_ra7[0] = 1'b0;  rf_ra7[1] = 1'b0;  rf_ra7[2] = 1'b0;  rf_ra7[3] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_addr(0, 0, 0, rf_pat[i][1], rf_pat[i][0]);
            BRFSH_N = 1'b0; BMREQ_N = 1'b0;
            repeat (2) tick();
            check_eq("rfsh_RAS_N", RAS_N, 1'b0);
            check_eq("rfsh_CAS1_N", CAS1_N, 1'b1);
            check_eq("rfsh_CAS2_N", CAS2_N, 1'b1);
            check_eq("rfsh_RA7", RA7, rf_ra7[i]);
            BRFSH_N = 1'b1; BMREQ_N = 1'b1;
            tick();
        end

        // DMA write into lower 32K with map=0000 goes to internal RAM
        DMA_N = 1'b0; BUSAK_N = 1'b0;
        set_addr(0, 0, 1, 0, 0);
        BMREQ_N = 1'b0; N_BWR = 1'b0;
        repeat (2) tick();
        check_eq("dma_CAS1_N", CAS1_N, 1'b0);
        check_eq("dma_BOOTROMCS_N", BOOTROMCS_N, 1'b1);
        check_eq("dma_ADDRBUFEN_N", ADDRBUFEN_N, 1'b1);
        check_eq("dma_BUSRQ_N", BUSRQ_N, 1'b0);
        bus_idle();
        tick();
        check_eq("dma_release_RAS_N", RAS_N, 1'b1);

        // Upper 32K write with map=0000: internal RAM, RA7 = BA7 then BA15
        set_addr(1, 0, 0, 0, 0);
        BMREQ_N = 1'b0; N_BWR = 1'b0;
        tick();
        check_eq("upper_RA7_row", RA7, 1'b0);
        tick();
        check_eq("upper_RA7_col", RA7, 1'b1);
        check_eq("upper_CAS1_N", CAS1_N, 1'b0);
        bus_idle();
        tick();

        // Map writes through port 0x7F, then a lower-32K read
        set_addr(0, 0, 0, 0, 1);
        set_data(4'b0101);
        IORQ_N = 1'b0; N_BWR = 1'b0;
        tick();
        bus_idle();
        set_addr(0, 1, 0, 0, 0);
        BMREQ_N = 1'b0; BRD_N = 1'b0;
        tick();
        check_eq("map0101_BOOTROMCS_N", BOOTROMCS_N, 1'b1);
        check_eq("map0101_RAS_N", RAS_N, 1'b0);
        bus_idle();
        tick();
        set_addr(0, 0, 0, 0, 1);
        set_data(4'b0000);
        IORQ_N = 1'b0; N_BWR = 1'b0;
        tick();
        bus_idle();
        set_addr(0, 1, 0, 0, 0);
        BMREQ_N = 1'b0; BRD_N = 1'b0;
        tick();
        check_eq("map0000_BOOTROMCS_N", BOOTROMCS_N, 1'b0);
        check_eq("map0000_RAS_N", RAS_N, 1'b1);
        bus_idle();
        tick();

        // Spinner interrupt disable
        set_addr(0, 0, 0, 1, 0);
        IORQ_N = 1'b0; BRD_N = 1'b0;
        tick();
        check_eq("spin_clear", SPINDIS_N, 1'b0);
        set_addr(0, 0, 0, 1, 1);
        tick();
        check_eq("spin_set", SPINDIS_N, 1'b1);
        bus_idle();
        tick();

        // Random bus activity
        for (int n = 0; n < 3000; n++) begin
            PBRST_N = ($urandom_range(0, 63) != 0);
            N_CVRST = ($urandom_range(0, 63) != 0);
            set_addr($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                     $urandom_range(0, 1), $urandom_range(0, 1));
            set_data(4'($urandom_range(0, 15)));
            BMREQ_N = ($urandom_range(0, 3) == 0);
            BRFSH_N = ($urandom_range(0, 5) != 0);
            BRD_N   = $urandom_range(0, 1);
            N_BWR   = $urandom_range(0, 1);
            IORQ_N  = ($urandom_range(0, 3) != 0);
            BM1_N   = ($urandom_range(0, 7) != 0);
            WAIT_N  = $urandom_range(0, 1);
            BUSAK_N = $urandom_range(0, 1);
            DMA_N   = ($urandom_range(0, 7) != 0);
            OS3_N   = ($urandom_range(0, 3) != 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
